// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: states, opcodes,
// ALU control codes and datapath select codes.
package riscv_ctrl_pkg;

    localparam int unsigned ST_W = 4;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, not on the FSM state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE: return IMM_S;
            OP_BEQ:   return IMM_B;
            OP_JAL:   return IMM_J;
            default:  return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// ALU control decode from the FSM's alu_op and the instruction funct fields.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Only R-type (op5=1) uses bit30 to select sub; addi ignores it.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared datapath
// through fetch/decode/execute/memory/writeback and stalls on mem_ready.
module riscv_multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W       = 4,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_o
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_next;
    alu_op_e         alu_op;
    logic            rdy;

    assign rdy     = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state_o = STATE_W'(state);
    assign imm_src = reset ? imm_sel(opcode) : IMM_I;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Moore decode; outputs are forced idle while reset is asserted so an
    // in-flight store strobe drops without waiting for a clock edge.
    always_comb begin
        state_next    = S_FETCH;
        mem_req       = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = rdy;
                pc_write   = rdy;
                state_next = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BEQ:            state_next = S_BEQ;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                state_next = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                state_next = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                pc_write  = zero;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            mem_req       = 1'b0;
            adr_src       = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            result_src    = RES_ALUOUT;
            alu_src_a     = SRCA_PC;
            alu_src_b     = SRCB_RS2;
            alu_op        = ALUOP_ADD;
            illegal_instr = 1'b0;
        end
    end

    riscv_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Self-checking bench for riscv_multicycle_controller: directed cases plus
// random instructions checked against a per-instruction cycle-plan model.
module tb_riscv_multicycle_controller;

    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_BEQ  = 7'b1100011;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr;
    logic [3:0] state_o;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // One expected cycle: state, mem_ready to drive, enables
    // {mem_req,adr_src,mem_write,ir_write,pc_write,reg_write}, selects, ALU op.
    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] en;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic       ill;
    } exp_t;

    riscv_multicycle_controller #(.STATE_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic rdy, input logic [5:0] en,
                                input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                input logic [2:0] alu, input logic ill);
        exp_t r;
        r.st = st; r.rdy = rdy; r.en = en; r.rs = rs;
        r.sa = sa; r.sb = sb; r.alu = alu; r.ill = ill;
        return r;
    endfunction

    function automatic logic [2:0] exp_funct(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (f7 && op[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (op)
            T_SW:    return 2'b01;
            T_BEQ:   return 2'b10;
            T_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit supported(input logic [6:0] op);
        return (op == T_LW) || (op == T_SW) || (op == T_R) || (op == T_I) ||
               (op == T_JAL) || (op == T_BEQ);
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_enables"}, 32'({mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                                    illegal_instr}), 32'd0);
        chk({tag, "_selects"}, 32'({result_src, alu_src_a, alu_src_b, imm_src, alu_control}), 32'd0);
    endtask

    // Builds the cycle plan of one instruction and checks the DUT against it.
    // Entered and left aligned to a falling clock edge, DUT in FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        exp_t       q[$];
        logic [2:0] fn;
        fn = exp_funct(op, f3, f7);
        repeat (fw) q.push_back(mk(4'd0, 1'b0, 6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0));
        q.push_back(mk(4'd0, 1'b1, 6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0));
        q.push_back(mk(4'd1, 1'($urandom), 6'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0));
        case (op)
            T_LW: begin
                q.push_back(mk(4'd2, 1'($urandom), 6'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0));
                repeat (mw) q.push_back(mk(4'd3, 1'b0, 6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                q.push_back(mk(4'd3, 1'b1, 6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                q.push_back(mk(4'd4, 1'($urandom), 6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0));
            end
            T_SW: begin
                q.push_back(mk(4'd2, 1'($urandom), 6'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0));
                repeat (mw) q.push_back(mk(4'd5, 1'b0, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                q.push_back(mk(4'd5, 1'b1, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
            end
            T_R: begin
                q.push_back(mk(4'd6, 1'($urandom), 6'b0, 2'b00, 2'b10, 2'b00, fn, 1'b0));
                q.push_back(mk(4'd8, 1'($urandom), 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
            end
            T_I: begin
                q.push_back(mk(4'd7, 1'($urandom), 6'b0, 2'b00, 2'b10, 2'b01, fn, 1'b0));
                q.push_back(mk(4'd8, 1'($urandom), 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
            end
            T_JAL: begin
                q.push_back(mk(4'd9, 1'($urandom), 6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0));
                q.push_back(mk(4'd8, 1'($urandom), 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
            end
            T_BEQ: q.push_back(mk(4'd10, 1'($urandom), {4'b0000, z, 1'b0}, 2'b00, 2'b10, 2'b00,
                                  3'b001, 1'b0));
            default: q.push_back(mk(4'd11, 1'($urandom), 6'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
        endcase
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            #1;
            chk("state", 32'(state_o), 32'(q[i].st));
            chk("enables", 32'({mem_req, adr_src, mem_write, ir_write, pc_write, reg_write}),
                32'(q[i].en));
            chk("selects", 32'({result_src, alu_src_a, alu_src_b, imm_src}),
                32'({q[i].rs, q[i].sa, q[i].sb, exp_imm(op)}));
            chk("alu_control", 32'(alu_control), 32'(q[i].alu));
            chk("illegal_instr", 32'(illegal_instr), 32'(q[i].ill));
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = T_JAL;
        funct3    = 3'b000;
        funct7b5  = 1'b1;
        zero      = 1'b1;

        repeat (5) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            #1;
            check_idle("reset");
        end
        reset = 1'b1;

        run_instr(T_R,   3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(T_LW,  3'b010, 1'b0, 1'b0, 2, 3);
        run_instr(T_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(T_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(T_R,   3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(T_I,   3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(T_R,   3'b110, 1'b0, 1'b0, 0, 0);
        run_instr(T_R,   3'b111, 1'b0, 1'b0, 0, 0);
        run_instr(T_I,   3'b010, 1'b0, 1'b0, 1, 0);
        run_instr(T_JAL, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(T_SW,  3'b010, 1'b0, 1'b0, 1, 2);
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b1, 0, 0);

        // Store interrupted by reset mid-wait: strobe must drop without a clock.
        opcode    = T_SW;
        mem_ready = 1'b1;
        #1;
        chk("sw_rst_fetch", 32'(state_o), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sw_rst_memwrite", 32'({state_o, mem_write}), 32'({4'd5, 1'b1}));
        @(negedge clk);
        #1;
        chk("sw_rst_wait", 32'({state_o, mem_write}), 32'({4'd5, 1'b1}));
        #1;
        reset = 1'b0;
        #1;
        chk("sw_rst_mem_write", 32'(mem_write), 32'd0);
        check_idle("sw_rst");
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 6))
                0: op = T_LW;
                1: op = T_SW;
                2: op = T_R;
                3: op = T_I;
                4: op = T_JAL;
                5: op = T_BEQ;
                default: begin
                    op = 7'($urandom);
                    while (supported(op)) op = 7'($urandom);
                end
            endcase
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I core that follows the single-cycle core. It sequences the shared datapath (one ALU, one unified instruction/data memory, PC/IR/ALUOut registers) through fetch, decode, execute, memory and writeback steps. It produces all datapath enables and mux selects, and stalls on a memory ready handshake. Supported instructions: lw, sw, R-type ALU, I-type ALU, jal, beq. All other opcodes trap.

Parameters:
STATE_W, 4, width of state register and state_o.
MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.

Ports:
clk  input  1  the single clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 = in reset.
opcode  input  7  instr[6:0] from IR.
funct3  input  3  instr[14:12].
funct7b5  input  1  instr[30].
zero  input  1  ALU zero flag.
mem_ready  input  1  memory completed the current access this cycle.
mem_req  output  1  memory access requested.
adr_src  output  1  0 = PC, 1 = ALUOut.
mem_write  output  1  store strobe.
ir_write  output  1  load IR (and OldPC).
pc_write  output  1  PC load enable.
reg_write  output  1  register file write.
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult.
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1.
alu_src_b  output  2  00 rs2, 01 Imm, 10 const 4.
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
imm_src  output  2  00 I, 01 S, 10 B, 11 J.
illegal_instr  output  1  one-cycle pulse on unsupported opcode.
state_o  output  STATE_W  current state, for debug.

Behaviour:
- Reset low forces state to FETCH asynchronously. While reset is low, all enables are 0 (mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr) and all selects are 0. state_o = FETCH (0).
- Outputs are Moore, decoded from the state. Exceptions: pc_write in BEQ is (zero), and ir_write/pc_write in FETCH are gated by mem_ready.
- imm_src is combinational from opcode: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Internal alu_op: 00 add, 01 sub, 10 funct. With alu_op = 10, funct3 decodes as follows:
  - 000: sub if (funct7b5 & opcode[5]), else add. addi with bit30 set is add.
  - 010: slt. 110: or. 111: and. Any other funct3: add.
- FETCH(0): mem_req=1, adr_src=0, src_a=00, src_b=10, add, result_src=10. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0. On mem_ready=1, goes to DECODE.
- DECODE(1): src_a=01, src_b=01, add (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1101111 -> JAL.
  - 1100011 -> BEQ.
  - else -> TRAP.
- MEMADR(2): src_a=10, src_b=01, add. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD(3): mem_req=1, adr_src=1, result_src=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB(4): result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE(5): mem_req=1, mem_write=1, adr_src=1, result_src=00. mem_write is held for the whole wait. Goes to FETCH on mem_ready.
- EXECR(6): src_a=10, src_b=00, alu_op=10. Goes to ALUWB.
- EXECI(7): src_a=10, src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB(8): result_src=00, reg_write=1. Goes to FETCH.
- JAL(9): src_a=01, src_b=10, add, result_src=00, pc_write=1. Goes to ALUWB.
- BEQ(10): src_a=10, src_b=00, sub, result_src=00, pc_write=zero. Goes to FETCH.
- TRAP(11): illegal_instr=1, no writes. Goes to FETCH.
- Unused encodings (12-15) go to FETCH next cycle with all enables 0.
- Reset taken mid-access (e.g. during a MEMWRITE wait) drops mem_write immediately. No partial writeback occurs.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 3.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - alu_control codes;
  - result_src, alu_src_a/b and imm_src select codes.
- One sub-module, riscv_alu_decoder: combinational; inputs alu_op, funct3, funct7b5, opcode[5]; output alu_control.

Test Plan:
- Reset held low 5 cycles, then released with mem_ready=1 and opcode=0110011 -> state_o sequence 0,1,6,8,0; reg_write=1 only in state 8; all enables 0 during reset.
- lw (0000011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> ir_write pulses once; states 0,0,0,1,2,3,3,3,3,4,0; mem_req high in every waiting cycle.
- beq (1100011) with zero=1, then repeated with zero=0 -> pc_write=1 in BEQ for the first run only; 3 cycles each.
- R-type sub (funct3 000, funct7b5=1) -> alu_control=001 in EXECR. addi (0010011, funct3 000, funct7b5=1) -> alu_control=000 in EXECI.
- sw with reset dropped after 1 cycle of MEMWRITE wait -> mem_write falls in the same cycle as reset without waiting for clk; state_o=0.
- Opcode 0000000 -> states 0,1,11,0; illegal_instr high exactly one cycle; no pc_write or reg_write after FETCH.
